decode_issue_stage: RTL and testbench
=====================================

DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 The module SHALL have parameters: WORD_SIZE, default 32, data width; NUM_REGS, default 32, register count; INDEX_WIDTH, default $clog2(NUM_REGS), register index width.
REQ-002 The module SHALL have these ports (clock and reset first):
  clk  in  1  clock, all state on rising edge
  reset  in  1  synchronous, active-high
  flush  in  1  discard held and issued-but-unconsumed instructions
  in_valid  in  1  fetch offers an instruction
  in_ready  out  1  stage accepts an instruction this cycle
  in_instr  in  32  RV32I instruction word
  in_pc  in  WORD_SIZE  instruction address
  rf_read_idx_1  out  INDEX_WIDTH  register file read port 1 index (rs1)
  rf_read_idx_2  out  INDEX_WIDTH  register file read port 2 index (rs2)
  rf_read_data_1  in  WORD_SIZE  register file read data 1, combinational
  rf_read_data_2  in  WORD_SIZE  register file read data 2, combinational
  wb_valid  in  1  writeback this cycle; the register file writes at the next edge
  wb_idx  in  INDEX_WIDTH  writeback destination
  wb_data  in  WORD_SIZE  writeback value
  out_valid  out  1  issued instruction valid toward execute
  out_ready  in  1  execute consumes the instruction
  out_instr, out_pc  out  32, WORD_SIZE  issued instruction word and address
  out_rs1_data, out_rs2_data  out  WORD_SIZE  operand values
  out_rd  out  INDEX_WIDTH  destination index
  out_writes_rd  out  1  instruction writes rd
REQ-003 Reset SHALL be reset, synchronous, active-high; the clock SHALL be clk.

Function
REQ-004 Field decode SHALL be: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0].
REQ-005 uses_rs1 SHALL be 0 for LUI 0110111, AUIPC 0010111 and JAL 1101111, and 1 otherwise.
REQ-006 uses_rs2 SHALL be 1 only for 0110011, STORE 0100011 and BRANCH 1100011.
REQ-007 writes_rd SHALL be 0 for STORE, BRANCH or rd==0, and 1 otherwise.
REQ-008 The stage SHALL hold one decode register D (d_valid plus the instruction and pc) and one output register O (out_valid plus the out_* fields).
REQ-009 in_ready SHALL equal !d_valid || issue, gated low while reset is high; an instruction SHALL be accepted when in_valid && in_ready.
REQ-010 rf_read_idx_1 and rf_read_idx_2 SHALL be driven combinationally from D's rs1 and rs2.
REQ-011 The scoreboard SHALL hold NUM_REGS busy bits, and busy[0] SHALL be constant 0.
REQ-012 A source is pending when its use bit is set && busy[rs] && !(wb_valid && wb_idx==rs).
REQ-013 hazard SHALL be pending(rs1) || pending(rs2) || (writes_rd && busy[rd] && !(wb_valid && wb_idx==rd)).
REQ-014 issue SHALL be d_valid && !hazard && (!out_valid || out_ready) && !flush.
REQ-015 Operand bypass: if wb_valid && wb_idx==rs && rs!=0, the operand SHALL be wb_data; otherwise it SHALL be rf_read_data; rs==0 SHALL give 0.
REQ-016 On issue, O SHALL load the D fields and bypassed operands with out_valid=1, and busy[rd] SHALL be set if writes_rd.
REQ-017 When out_valid && out_ready && !issue, out_valid SHALL clear; O SHALL hold stable while out_valid && !out_ready.
REQ-018 wb_valid SHALL clear busy[wb_idx]; if issue sets the same index in that cycle, the set SHALL win.
REQ-019 Latency: an instruction accepted at edge N with no hazard and O free SHALL present out_valid after edge N+1; sustained throughput SHALL be 1 per cycle.
REQ-020 flush SHALL clear d_valid and out_valid at the next edge, clear busy[out_rd] if out_valid && out_writes_rd, and accept no input in that cycle.
REQ-021 A wb_valid in a flush cycle SHALL still clear its busy bit.

Reset
REQ-022 While reset is high, at each edge all busy bits, d_valid and out_valid SHALL be 0; all out_* data SHALL be 0; in_ready SHALL be 0.
REQ-023 Reset SHALL override flush, issue and writeback, and reset mid-hazard SHALL discard the stalled instruction.

Verification
REQ-024 add x3,x1,x2 (0x002081B3) with x1=5, x2=7 and out_ready=1 -> out_valid after 2 edges, out_rs1_data=5, out_rs2_data=7, out_rd=3, out_writes_rd=1, busy[3]=1.
REQ-025 addi x4,x3,1 directly after the add, with no writeback -> in_ready=0, out_valid=0 while stalled; wb_valid, wb_idx=3, wb_data=12 -> issues that cycle with out_rs1_data=12, busy[3]=0, busy[4]=1.
REQ-026 out_ready=0 with 3 instructions offered back-to-back -> one in O, one in D, in_ready=0, O stable; out_ready=1 -> all drain in order, one per cycle.
REQ-027 sw x5,0(x0) and beq x0,x0 -> out_writes_rd=0, no busy bit set; lui x0,1 -> out_writes_rd=0.
REQ-028 flush with O holding add x6 and D valid -> next cycle out_valid=0, d_valid=0, busy[6]=0.
REQ-029 reset asserted during a stall with busy[3]=1 -> after reset, all busy bits 0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: one decode register (D) feeding one issue register (O),
// with a busy-bit scoreboard for RAW/WAW stalls and writeback operand bypass.
module decode_issue_stage #(
    parameter int WORD_SIZE   = 32,
    parameter int NUM_REGS    = 32,
    parameter int INDEX_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [WORD_SIZE-1:0]   in_pc,
    output logic [INDEX_WIDTH-1:0] rf_read_idx_1,
    output logic [INDEX_WIDTH-1:0] rf_read_idx_2,
    input  logic [WORD_SIZE-1:0]   rf_read_data_1,
    input  logic [WORD_SIZE-1:0]   rf_read_data_2,
    input  logic                   wb_valid,
    input  logic [INDEX_WIDTH-1:0] wb_idx,
    input  logic [WORD_SIZE-1:0]   wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [WORD_SIZE-1:0]   out_pc,
    output logic [WORD_SIZE-1:0]   out_rs1_data,
    output logic [WORD_SIZE-1:0]   out_rs2_data,
    output logic [INDEX_WIDTH-1:0] out_rd,
    output logic                   out_writes_rd
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic                   d_valid_q, d_valid_d;
    logic [31:0]            d_instr_q, d_instr_d;
    logic [WORD_SIZE-1:0]   d_pc_q, d_pc_d;

    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_instr_q, out_instr_d;
    logic [WORD_SIZE-1:0]   out_pc_q, out_pc_d;
    logic [WORD_SIZE-1:0]   out_rs1_data_q, out_rs1_data_d;
    logic [WORD_SIZE-1:0]   out_rs2_data_q, out_rs2_data_d;
    logic [INDEX_WIDTH-1:0] out_rd_q, out_rd_d;
    logic                   out_writes_rd_q, out_writes_rd_d;

    logic [NUM_REGS-1:0]    busy_q, busy_d;

    logic [6:0]             opcode;
    logic [INDEX_WIDTH-1:0] rs1, rs2, rd;
    logic                   uses_rs1, uses_rs2, writes_rd;
    logic                   wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic                   hazard, issue, accept;
    logic [WORD_SIZE-1:0]   rs1_data, rs2_data;

    assign opcode = d_instr_q[6:0];
    assign rs1    = INDEX_WIDTH'(d_instr_q[19:15]);
    assign rs2    = INDEX_WIDTH'(d_instr_q[24:20]);
    assign rd     = INDEX_WIDTH'(d_instr_q[11:7]);

    assign uses_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2  = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
    assign writes_rd = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != '0);

    assign wb_hit_rs1 = wb_valid && (wb_idx == rs1);
    assign wb_hit_rs2 = wb_valid && (wb_idx == rs2);
    assign wb_hit_rd  = wb_valid && (wb_idx == rd);

    // A writeback landing this cycle resolves the dependency, so it never stalls.
    assign hazard = (uses_rs1 && busy_q[rs1] && !wb_hit_rs1)
                 || (uses_rs2 && busy_q[rs2] && !wb_hit_rs2)
                 || (writes_rd && busy_q[rd] && !wb_hit_rd);

    assign issue    = d_valid_q && !hazard && (!out_valid_q || out_ready) && !flush;
    assign in_ready = !reset && !flush && (!d_valid_q || issue);
    assign accept   = in_valid && in_ready;

    assign rf_read_idx_1 = rs1;
    assign rf_read_idx_2 = rs2;

    assign rs1_data = (rs1 == '0) ? '0 : (wb_hit_rs1 ? wb_data : rf_read_data_1);
    assign rs2_data = (rs2 == '0) ? '0 : (wb_hit_rs2 ? wb_data : rf_read_data_2);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        d_valid_d       = d_valid_q;
        d_instr_d       = d_instr_q;
        d_pc_d          = d_pc_q;
        out_valid_d     = out_valid_q;
        out_instr_d     = out_instr_q;
        out_pc_d        = out_pc_q;
        out_rs1_data_d  = out_rs1_data_q;
        out_rs2_data_d  = out_rs2_data_q;
        out_rd_d        = out_rd_q;
        out_writes_rd_d = out_writes_rd_q;
        busy_d          = busy_q;

        if (accept) begin
            d_valid_d = 1'b1;
            d_instr_d = in_instr;
            d_pc_d    = in_pc;
        end else if (issue || flush) begin
            d_valid_d = 1'b0;
        end

        if (issue) begin
            out_valid_d     = 1'b1;
            out_instr_d     = d_instr_q;
            out_pc_d        = d_pc_q;
            out_rs1_data_d  = rs1_data;
            out_rs2_data_d  = rs2_data;
            out_rd_d        = rd;
            out_writes_rd_d = writes_rd;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end

        // Later assignments win: issue's set overrides a same-index writeback clear.
        if (wb_valid)
            busy_d[wb_idx] = 1'b0;
        if (flush && out_valid_q && out_writes_rd_q)
            busy_d[out_rd_q] = 1'b0;
        if (issue && writes_rd)
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only here, so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: the scoreboard is cleared as one vector; a stale busy bit would stall forever.
            d_valid_q       <= 1'b0;
            d_instr_q       <= '0;
            d_pc_q          <= '0;
            out_valid_q     <= 1'b0;
            out_instr_q     <= '0;
            out_pc_q        <= '0;
            out_rs1_data_q  <= '0;
            out_rs2_data_q  <= '0;
            out_rd_q        <= '0;
            out_writes_rd_q <= 1'b0;
            busy_q          <= '0;
        end else begin
            d_valid_q       <= d_valid_d;
            d_instr_q       <= d_instr_d;
            d_pc_q          <= d_pc_d;
            out_valid_q     <= out_valid_d;
            out_instr_q     <= out_instr_d;
            out_pc_q        <= out_pc_d;
            out_rs1_data_q  <= out_rs1_data_d;
            out_rs2_data_q  <= out_rs2_data_d;
            out_rd_q        <= out_rd_d;
            out_writes_rd_q <= out_writes_rd_d;
            busy_q          <= busy_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_instr     = out_instr_q;
    assign out_pc        = out_pc_q;
    assign out_rs1_data  = out_rs1_data_q;
    assign out_rs2_data  = out_rs2_data_q;
    assign out_rd        = out_rd_q;
    assign out_writes_rd = out_writes_rd_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed scenarios followed by a randomized in-order stream checked against
// a program-order architectural register model.
module tb_decode_issue_stage;
    localparam int W      = 32;
    localparam int NR     = 32;
    localparam int IW     = 5;
    localparam int N_RAND = 150;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready;
    logic [31:0]   in_instr;
    logic [W-1:0]  in_pc;
    logic [IW-1:0] rf_read_idx_1, rf_read_idx_2;
    logic [W-1:0]  rf_read_data_1, rf_read_data_2;
    logic          wb_valid;
    logic [IW-1:0] wb_idx;
    logic [W-1:0]  wb_data;
    logic          out_valid, out_ready;
    logic [31:0]   out_instr;
    logic [W-1:0]  out_pc, out_rs1_data, out_rs2_data;
    logic [IW-1:0] out_rd;
    logic          out_writes_rd;

    always #5 clk = ~clk;

    decode_issue_stage #(.WORD_SIZE(W), .NUM_REGS(NR), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_read_idx_1(rf_read_idx_1), .rf_read_idx_2(rf_read_idx_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_writes_rd(out_writes_rd)
    );

    // Register file environment: written at the edge after a writeback, read combinationally.
    logic [W-1:0] rf_mem [NR];
    always @(posedge clk) if (wb_valid && wb_idx != '0) rf_mem[wb_idx] <= wb_data;
    assign rf_read_data_1 = rf_mem[rf_read_idx_1];
    assign rf_read_data_2 = rf_mem[rf_read_idx_2];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic writeback(input logic [4:0] idx, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_idx   = idx;
        wb_data  = data;
        tick();
        wb_valid = 1'b0;
    endtask

    function automatic logic m_uses1(input logic [31:0] i);
        return !(i[6:0] == 7'b0110111 || i[6:0] == 7'b0010111 || i[6:0] == 7'b1101111);
    endfunction
    function automatic logic m_uses2(input logic [31:0] i);
        return i[6:0] == 7'b0110011 || i[6:0] == 7'b0100011 || i[6:0] == 7'b1100011;
    endfunction
    function automatic logic m_wrd(input logic [31:0] i);
        return !(i[6:0] == 7'b0100011 || i[6:0] == 7'b1100011) && i[11:7] != 5'd0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 6))
            0:       op = 7'b0110011;
            1:       op = 7'b0010011;
            2:       op = 7'b0100011;
            3:       op = 7'b1100011;
            4:       op = 7'b0110111;
            5:       op = 7'b0010111;
            default: op = 7'b1101111;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom_range(0, 7)), op};
    endfunction

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;

    localparam logic [31:0] ADD_X3  = 32'h002081B3;
    localparam logic [31:0] ADD_X6  = 32'h00208333;
    localparam logic [31:0] ADDI_X4 = 32'h00118213;

    initial begin
        logic [31:0] bp_instr [3];
        logic [31:0] nw_instr [3];
        ent_t        exp_q [$];
        logic [36:0] wb_q [$];
        logic [31:0] arch [8];
        logic [31:0] gen_instr, gen_pc, res;
        ent_t        e;
        int          n_acc, n_con;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_valid = 1'b0; wb_idx = '0; wb_data = '0; out_ready = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", dut.busy_q, 0);
        check("rst_out_rs1", out_rs1_data, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        writeback(5'd1, 32'd5);
        writeback(5'd2, 32'd7);

        // add x3,x1,x2 followed directly by dependent addi x4,x3,1
        out_ready = 1'b1;
        present(ADD_X3, 32'h100);
        #1 check("add_in_ready", in_ready, 1);
        tick();
        present(ADDI_X4, 32'h104);
        #1 check("add_lat_one_edge", out_valid, 0);
        check("addi_accepted", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("add_out_valid", out_valid, 1);
        check("add_rs1", out_rs1_data, 5);
        check("add_rs2", out_rs2_data, 7);
        check("add_rd", out_rd, 3);
        check("add_wrd", out_writes_rd, 1);
        check("add_pc", out_pc, 32'h100);
        check("add_busy3", dut.busy_q[3], 1);
        #1 check("addi_stall_ready", in_ready, 0);
        tick();
        check("addi_stall_out_valid", out_valid, 0);
        check("addi_stall_ready2", in_ready, 0);
        wb_valid = 1'b1; wb_idx = 5'd3; wb_data = 32'd12;
        #1 check("addi_wb_unstall", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        check("addi_out_valid", out_valid, 1);
        check("addi_bypass_rs1", out_rs1_data, 12);
        check("addi_rd", out_rd, 4);
        check("addi_busy3", dut.busy_q[3], 0);
        check("addi_busy4", dut.busy_q[4], 1);
        tick();
        check("addi_consumed", out_valid, 0);
        writeback(5'd4, 32'd13);

        // Backpressure: three independent instructions with execute stalled
        bp_instr[0] = 32'h00100393; bp_instr[1] = 32'h00200413; bp_instr[2] = 32'h00300493;
        out_ready = 1'b0;
        present(bp_instr[0], 32'h200);
        #1 check("bp_ready0", in_ready, 1);
        tick();
        present(bp_instr[1], 32'h204);
        #1 check("bp_ready1", in_ready, 1);
        tick();
        present(bp_instr[2], 32'h208);
        #1 check("bp_full_ready", in_ready, 0);
        check("bp_o_holds_i0", out_instr, bp_instr[0]);
        check("bp_d_valid", dut.d_valid_q, 1);
        tick();
        check("bp_o_stable", out_instr, bp_instr[0]);
        check("bp_o_stable_valid", out_valid, 1);
        check("bp_full_ready2", in_ready, 0);
        tick();
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_drain_i1", out_instr, bp_instr[1]);
        check("bp_drain_i1_pc", out_pc, 32'h204);
        tick();
        check("bp_drain_i2", out_instr, bp_instr[2]);
        check("bp_drain_i2_valid", out_valid, 1);
        tick();
        check("bp_empty", out_valid, 0);
        writeback(5'd7, 32'd1);
        writeback(5'd8, 32'd2);
        writeback(5'd9, 32'd3);

        // Non-writing instructions: sw x5,0(x0), beq x0,x0, lui x0,1
        nw_instr[0] = 32'h00502023; nw_instr[1] = 32'h00000063; nw_instr[2] = 32'h00001037;
        for (int i = 0; i < 3; i++) begin
            present(nw_instr[i], 32'h300 + 32'(4 * i));
            tick();
            in_valid = 1'b0;
            tick();
            check($sformatf("nw%0d_valid", i), out_valid, 1);
            check($sformatf("nw%0d_wrd", i), out_writes_rd, 0);
            check($sformatf("nw%0d_busy", i), dut.busy_q, 0);
            tick();
        end

        // Flush with O holding add x6 and D valid
        out_ready = 1'b0;
        present(ADD_X6, 32'h400);
        tick();
        present(bp_instr[0], 32'h404);
        tick();
        check("fl_pre_busy6", dut.busy_q[6], 1);
        check("fl_pre_out_valid", out_valid, 1);
        check("fl_pre_d_valid", dut.d_valid_q, 1);
        flush = 1'b1;
        #1 check("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_d_valid", dut.d_valid_q, 0);
        check("fl_busy6", dut.busy_q[6], 0);

        // Reset during a RAW stall
        out_ready = 1'b1;
        present(ADD_X3, 32'h500);
        tick();
        present(ADDI_X4, 32'h504);
        tick();
        in_valid = 1'b0;
        tick();
        check("rs_stalled", in_ready, 0);
        check("rs_busy3", dut.busy_q[3], 1);
        reset = 1'b1;
        tick();
        check("rs_in_ready_low", in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rs_busy_clear", dut.busy_q, 0);
        check("rs_out_valid", out_valid, 0);
        check("rs_d_valid", dut.d_valid_q, 0);
        check("rs_in_ready", in_ready, 1);

        // Randomized stream against a program-order architectural model
        arch[0] = '0;
        for (int r = 1; r < 8; r++) begin
            arch[r] = $urandom;
            writeback(5'(r), arch[r]);
        end
        gen_instr = rand_instr();
        gen_pc    = 32'h1000;
        n_acc = 0;
        n_con = 0;
        for (int cyc = 0; cyc < 5000 && n_con < N_RAND; cyc++) begin
            in_valid  = (n_acc < N_RAND) && ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr;
            in_pc     = gen_pc;
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = (wb_q.size() != 0) && ($urandom_range(0, 2) != 0);
            if (wb_q.size() != 0) {wb_idx, wb_data} = wb_q[0];
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back('{gen_instr, gen_pc});
                n_acc++;
                gen_instr = rand_instr();
                gen_pc    = gen_pc + 32'd4;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious_issue", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_instr", out_instr, e.instr);
                    check("rand_pc", out_pc, e.pc);
                    check("rand_rd", out_rd, e.instr[11:7]);
                    check("rand_wrd", out_writes_rd, m_wrd(e.instr));
                    if (m_uses1(e.instr)) check("rand_rs1", out_rs1_data, arch[e.instr[17:15]]);
                    if (m_uses2(e.instr)) check("rand_rs2", out_rs2_data, arch[e.instr[22:20]]);
                    if (m_wrd(e.instr)) begin
                        res = $urandom;
                        arch[e.instr[9:7]] = res;
                        wb_q.push_back({e.instr[11:7], res});
                    end
                    n_con++;
                end
            end
            if (wb_valid) void'(wb_q.pop_front());
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wb_valid = 1'b0;
        check("rand_all_consumed", 64'(n_con), 64'(N_RAND));
        check("rand_queue_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
